// File: rtl/key_irq_ctrl.sv
// Key-line interrupt controller: synchronises and debounces keys, latches rising edges
// as pending requests, and arbitrates one request at a time to the fetch PC mux.
module key_irq_ctrl #(
  parameter int          NKEYS           = 4,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter logic [31:0] VECTOR_BASE     = 32'd148,
  parameter logic [31:0] VECTOR_STRIDE   = 32'd16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NKEYS-1:0] key_in,
  input  logic [NKEYS-1:0] irq_mask,
  input  logic [31:0]      pc_in,
  input  logic             irq_ack,
  input  logic             irq_ret,
  output logic             irq_req,
  output logic [31:0]      irq_vector,
  output logic [1:0]       irq_id,
  output logic [31:0]      epc,
  output logic             in_service,
  output logic [NKEYS-1:0] pending
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQUEST, SERVICE} state_t;

  state_t           state;
  logic [NKEYS-1:0] sync1;
  logic [NKEYS-1:0] key_s;
  logic [NKEYS-1:0] stable;
  logic [NKEYS-1:0] rise;
  logic [NKEYS-1:0] clr;
  logic [CW-1:0]    cnt [NKEYS];
  logic [1:0]       win;

  // rise fires on the same edge that the debounced level flips 0->1
  always_comb begin
    rise = '0;
    clr  = '0;
    for (int i = 0; i < NKEYS; i++) begin
      rise[i] = irq_mask[i] && !stable[i] && key_s[i] && (cnt[i] == CNT_LAST);
      clr[i]  = (state == REQUEST) && irq_ack && (irq_id == 2'(i));
    end
  end

  always_comb begin
    win = 2'd0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (pending[i]) win = 2'(i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= '0;
      key_s   <= '0;
      stable  <= '0;
      pending <= '0;
      for (int i = 0; i < NKEYS; i++) cnt[i] <= '0;
    end else begin
      sync1 <= key_in;
      key_s <= sync1;
      for (int i = 0; i < NKEYS; i++) begin
        if (key_s[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= key_s[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
      // a new edge on the bit being acknowledged outranks the clear
      pending <= (pending & ~clr) | rise;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      irq_req    <= 1'b0;
      irq_id     <= 2'd0;
      irq_vector <= 32'd0;
      epc        <= 32'd0;
      in_service <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|pending) begin
            state      <= REQUEST;
            irq_req    <= 1'b1;
            irq_id     <= win;
            irq_vector <= VECTOR_BASE + 32'(win) * VECTOR_STRIDE;
          end
        end
        REQUEST: begin
          if (irq_ack) begin
            state      <= SERVICE;
            irq_req    <= 1'b0;
            in_service <= 1'b1;
            epc        <= pc_in;
          end
        end
        SERVICE: begin
          if (irq_ret) begin
            state      <= IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          irq_req    <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_irq_ctrl.sv
// Directed bench for key_irq_ctrl with a short debounce window (4 cycles).
module tb_key_irq_ctrl;

  logic        clk;
  logic        reset;
  logic [3:0]  key_in;
  logic [3:0]  irq_mask;
  logic [31:0] pc_in;
  logic        irq_ack;
  logic        irq_ret;
  logic        irq_req;
  logic [31:0] irq_vector;
  logic [1:0]  irq_id;
  logic [31:0] epc;
  logic        in_service;
  logic [3:0]  pending;

  int n_checks = 0;
  int n_errs   = 0;

  key_irq_ctrl #(
    .NKEYS          (4),
    .DEBOUNCE_CYCLES(4),
    .VECTOR_BASE    (32'd148),
    .VECTOR_STRIDE  (32'd16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_in    (key_in),
    .irq_mask  (irq_mask),
    .pc_in     (pc_in),
    .irq_ack   (irq_ack),
    .irq_ret   (irq_ret),
    .irq_req   (irq_req),
    .irq_vector(irq_vector),
    .irq_id    (irq_id),
    .epc       (epc),
    .in_service(in_service),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},  32'(irq_req),    32'd0);
    check({tag, "_vec"},  irq_vector,      32'd0);
    check({tag, "_id"},   32'(irq_id),     32'd0);
    check({tag, "_epc"},  epc,             32'd0);
    check({tag, "_srv"},  32'(in_service), 32'd0);
    check({tag, "_pend"}, 32'(pending),    32'd0);
  endtask

  initial begin
    reset    = 1'b0;
    key_in   = 4'hF;
    irq_mask = 4'hF;
    pc_in    = 32'd0;
    irq_ack  = 1'b0;
    irq_ret  = 1'b0;

    // T1: reset with keys held high, then release
    tick(3);
    check_all_zero("t1_rst");
    reset = 1'b1;
    tick(5);
    check("t1_pend_before_debounce", 32'(pending), 32'h0);
    tick(1);
    check("t1_pend_after_debounce", 32'(pending), 32'hF);
    check("t1_req_not_yet", 32'(irq_req), 32'd0);
    tick(1);
    check("t1_req", 32'(irq_req), 32'd1);
    check("t1_vec", irq_vector, 32'd148);
    // async reset mid-REQUEST
    reset  = 1'b0;
    key_in = 4'h0;
    #1;
    check_all_zero("t1_async");
    tick(1);
    reset = 1'b1;
    tick(3);

    // T2: short glitch ignored, long press accepted
    key_in = 4'b0100;
    tick(3);
    key_in = 4'b0000;
    tick(8);
    check("t2_glitch_pend", 32'(pending), 32'h0);
    check("t2_glitch_req", 32'(irq_req), 32'd0);
    key_in = 4'b0100;
    tick(5);
    check("t2_pend_edge5", 32'(pending), 32'h0);
    tick(1);
    check("t2_pend_edge6", 32'(pending), 32'h4);
    check("t2_req_edge6", 32'(irq_req), 32'd0);
    tick(1);
    check("t2_req_edge7", 32'(irq_req), 32'd1);
    check("t2_id", 32'(irq_id), 32'd2);
    check("t2_vec", irq_vector, 32'd180);

    // T3: ack together with ret takes ack only
    pc_in   = 32'h40;
    irq_ack = 1'b1;
    irq_ret = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    irq_ret = 1'b0;
    key_in  = 4'b0000;
    check("t3_srv", 32'(in_service), 32'd1);
    check("t3_epc", epc, 32'h40);
    check("t3_pend", 32'(pending), 32'h0);
    check("t3_req_low", 32'(irq_req), 32'd0);
    // ack in SERVICE is ignored
    pc_in   = 32'h99;
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    check("t3_ack_ignored_epc", epc, 32'h40);
    check("t3_ack_ignored_srv", 32'(in_service), 32'd1);
    irq_ret = 1'b1;
    tick(1);
    irq_ret = 1'b0;
    check("t3_ret_srv", 32'(in_service), 32'd0);
    tick(6);
    check("t3_release_no_pend", 32'(pending), 32'h0);
    check("t3_idle_req", 32'(irq_req), 32'd0);

    // T4: simultaneous keys 1 and 3, fixed priority
    key_in = 4'b1010;
    tick(6);
    check("t4_pend", 32'(pending), 32'hA);
    tick(1);
    key_in = 4'b0000;
    check("t4_id1", 32'(irq_id), 32'd1);
    check("t4_vec1", irq_vector, 32'd164);
    pc_in   = 32'h100;
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    check("t4_pend_after_ack", 32'(pending), 32'h8);
    check("t4_epc", epc, 32'h100);
    irq_ret = 1'b1;
    tick(1);
    irq_ret = 1'b0;
    check("t4_ret_srv", 32'(in_service), 32'd0);
    check("t4_ret_req", 32'(irq_req), 32'd0);
    tick(1);
    check("t4_req3", 32'(irq_req), 32'd1);
    check("t4_id3", 32'(irq_id), 32'd3);
    check("t4_vec3", irq_vector, 32'd196);
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    irq_ret = 1'b1;
    tick(1);
    irq_ret = 1'b0;
    tick(8);
    check("t4_done_pend", 32'(pending), 32'h0);
    check("t4_done_req", 32'(irq_req), 32'd0);

    // T5: masked key never pends
    irq_mask = 4'b1110;
    key_in   = 4'b0001;
    tick(8);
    check("t5_masked_pend", 32'(pending), 32'h0);
    check("t5_masked_req", 32'(irq_req), 32'd0);
    key_in = 4'b0000;
    tick(8);
    irq_mask = 4'hF;
    key_in   = 4'b0010;
    tick(7);
    check("t5_req1", 32'(irq_req), 32'd1);
    check("t5_id1", 32'(irq_id), 32'd1);
    // release and re-press key 1 while REQUEST stays up; ret here is ignored
    key_in = 4'b0000;
    tick(4);
    irq_ret = 1'b1;
    tick(1);
    irq_ret = 1'b0;
    check("t5_ret_outside_req", 32'(irq_req), 32'd1);
    check("t5_ret_outside_srv", 32'(in_service), 32'd0);
    tick(3);
    key_in = 4'b0010;
    tick(5);
    pc_in   = 32'h50;
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    check("t5_set_wins_pend", 32'(pending), 32'h2);
    check("t5_srv", 32'(in_service), 32'd1);
    check("t5_epc", epc, 32'h50);
    // key 0 edge during SERVICE
    key_in = 4'b0011;
    tick(6);
    check("t5_pend_in_srv", 32'(pending), 32'h3);
    irq_mask = 4'h0;
    tick(1);
    check("t5_mask_keeps_pend", 32'(pending), 32'h3);
    irq_ret = 1'b1;
    tick(1);
    irq_ret = 1'b0;
    tick(1);
    check("t5_req0", 32'(irq_req), 32'd1);
    check("t5_id0", 32'(irq_id), 32'd0);
    check("t5_vec0", irq_vector, 32'd148);
    pc_in   = 32'h88;
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    check("t5_pend_left", 32'(pending), 32'h2);
    check("t6_epc_before", epc, 32'h88);

    // T6: async reset mid-SERVICE takes effect without a clock edge
    #2;
    reset = 1'b0;
    #1;
    check("t6_srv", 32'(in_service), 32'd0);
    check("t6_epc", epc, 32'd0);
    check("t6_req", 32'(irq_req), 32'd0);
    check("t6_pend", 32'(pending), 32'd0);
    tick(2);
    reset = 1'b1;
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
